// File: rtl/ftdi_wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// ftdi_wb_arb_pkg
// Shared types and constants for the FTDI two-master Wishbone arbiter.
//   ADDR_W / DATA_W / SEL_W : Wishbone bus widths
//   arb_state_e             : arbiter ownership state
// ----------------------------------------------------------------------------
package ftdi_wb_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/wb_outst_ctr.sv
// ----------------------------------------------------------------------------
// wb_outst_ctr
// Saturating up/down counter of Wishbone requests issued but not yet acked.
//   clk_i      : clock
//   rst_i      : synchronous active-low reset
//   inc        : a request was accepted by the slave this cycle
//   dec        : the slave acked this cycle
//   full       : 2**OUTST_W-1 requests in flight, no more may issue
//   empty      : nothing in flight
//   next_empty : nothing will be in flight after this edge
//   err        : sticky, an ack arrived with nothing in flight
// ----------------------------------------------------------------------------
module wb_outst_ctr #(
  parameter int OUTST_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty,
  output logic next_empty,
  output logic err
);

  logic [OUTST_W-1:0] count_q;
  logic [OUTST_W-1:0] count_d;
  logic               inc_ok;
  logic               dec_ok;

  assign full  = (count_q == {OUTST_W{1'b1}});
  assign empty = (count_q == '0);

  // Stray acks are dropped rather than wrapping the counter below zero;
  // an increment at full cannot happen because the issue path is blocked.
  assign inc_ok = inc & ~full;
  assign dec_ok = dec & ~empty;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (inc_ok && !dec_ok) begin
      count_d = count_q + OUTST_W'(1);
    end else if (dec_ok && !inc_ok) begin
      count_d = count_q - OUTST_W'(1);
    end
  end

  assign next_empty = (count_d == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q <= '0;
      err     <= 1'b0;
    end else begin
      count_q <= count_d;
      if (dec && empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ftdi_wb_arbiter.sv
// ----------------------------------------------------------------------------
// ftdi_wb_arbiter
// Two-master pipelined Wishbone arbiter (stb/stall/ack) in front of one slave.
// Master 0 is the FTDI async bridge, master 1 an on-chip master. Whole bus
// cycles are granted round-robin (optionally master 0 wins ties); the bus is
// handed back only after every outstanding request has been acked.
//   clk_i, rst_i            : clock, synchronous active-low reset
//   mN_addr/data/sel/we_i   : master N request fields
//   mN_cyc_i, mN_stb_i      : master N cycle / strobe
//   mN_data_o               : slave read data (unqualified, both masters)
//   mN_stall_o, mN_ack_o    : master N flow control / ack
//   s_addr/data/sel/we_o    : request fields of the current owner
//   s_cyc_o, s_stb_o        : slave cycle / strobe
//   s_data_i, s_stall_i,
//   s_ack_i                 : slave response
//   err_o                   : sticky, ack seen with nothing outstanding
// ----------------------------------------------------------------------------
module ftdi_wb_arbiter
  import ftdi_wb_arb_pkg::*;
#(
  parameter int OUTST_W     = 4,
  parameter bit M0_PRIORITY = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // master 0
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic              m0_we_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  output logic              m0_stall_o,
  output logic              m0_ack_o,
  // master 1
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic              m1_we_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  output logic              m1_stall_o,
  output logic              m1_ack_o,
  // slave
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_stall_i,
  input  logic              s_ack_i,
  output logic              err_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // 1: master 1 won the last arbitration
  logic       req0, req1, grant1;
  logic       own_cyc, own_stb;
  logic       own_stall, own_ack;
  logic       full, empty, next_empty, issue;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // On a tie master 1 wins only under round-robin when master 0 went last.
  assign grant1 = req1 & (~req0 | (~M0_PRIORITY & ~last_q));

  // The last winner is always the current owner in OWN/DRAIN, so it alone
  // steers the request mux and the ack/stall routing.
  assign own_cyc = last_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = last_q ? m1_stb_i : m0_stb_i;

  assign s_addr_o = last_q ? m1_addr_i : m0_addr_i;
  assign s_data_o = last_q ? m1_data_i : m0_data_i;
  assign s_sel_o  = last_q ? m1_sel_i  : m0_sel_i;
  assign s_we_o   = last_q ? m1_we_i   : m0_we_i;

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  assign issue = s_stb_o & ~s_stall_i;

  wb_outst_ctr #(
    .OUTST_W (OUTST_W)
  ) u_outst_ctr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc        (issue),
    .dec        (s_ack_i),
    .full       (full),
    .empty      (empty),
    .next_empty (next_empty),
    .err        (err_o)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    own_stall = 1'b1;
    own_ack   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = grant1 ? OWN1 : OWN0;
          last_d  = grant1;
        end
      end
      OWN0, OWN1: begin
        s_cyc_o   = 1'b1;
        s_stb_o   = own_stb & ~full;
        own_stall = s_stall_i | full;
        own_ack   = s_ack_i;
        // A final ack landing with the cyc drop skips DRAIN entirely.
        if (!own_cyc) begin
          state_d = next_empty ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        // Owner stays stalled even if it re-raises cyc: it must re-arbitrate.
        s_cyc_o = 1'b1;
        own_ack = s_ack_i;
        if (empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_stall_o = last_q ? 1'b1 : own_stall;
  assign m1_stall_o = last_q ? own_stall : 1'b1;
  assign m0_ack_o   = last_q ? 1'b0 : own_ack;
  assign m1_ack_o   = last_q ? own_ack : 1'b0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_ftdi_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ftdi_wb_arbiter
// Directed bench for ftdi_wb_arbiter. Master drivers push the expected slave
// request and the expected ack (owner, read data) into queues as each strobe
// is accepted; a monitor pops and compares whenever the slave accepts a
// request or a master sees an ack. A second instance with M0_PRIORITY=1
// covers the tie-break option.
// ----------------------------------------------------------------------------
module tb_ftdi_wb_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [3:0]  sel;
  } req_t;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] rdata;
  } ack_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;

  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [3:0]  m_sel  [2];
  logic        m_we   [2];
  logic        m_cyc  [2];
  logic        m_stb  [2];

  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, err_o;
  logic [31:0] s_data_i  = '0;
  logic        s_stall_i = 1'b0;
  logic        s_ack_i   = 1'b0;

  // priority-variant instance signals
  logic        p_cyc0 = 1'b0, p_cyc1 = 1'b0, p_ack = 1'b0;
  logic [31:0] p_m0_data, p_m1_data, p_s_addr, p_s_data;
  logic [3:0]  p_s_sel;
  logic        p_m0_stall, p_m1_stall, p_m0_ack, p_m1_ack;
  logic        p_s_we, p_s_cyc, p_s_stb, p_err;

  int checks = 0;
  int failures = 0;

  req_t        exp_q [$];
  ack_t        ack_q [$];
  int          issue_log [$];
  int          issued_cnt [2];
  int          ack_cnt [2];
  logic [31:0] ref_mem [logic [31:0]];
  int          viol = 0;      // both masters unstalled at once
  int          viol1 = 0;     // master 1 activity while it should be idle
  logic        t1_watch = 1'b0;
  logic        stall_en = 1'b0;
  logic        ack_en = 1'b1;
  logic        force_ack = 1'b0;

  always #5 clk_i = ~clk_i;

  ftdi_wb_arbiter #(.OUTST_W(2), .M0_PRIORITY(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_data[0]), .m0_data_o(m0_data_o),
    .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
    .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_data[1]), .m1_data_o(m1_data_o),
    .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
    .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_data_i(s_data_i),
    .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .err_o(err_o)
  );

  ftdi_wb_arbiter #(.OUTST_W(4), .M0_PRIORITY(1'b1)) dut_p (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(32'h10), .m0_data_i(32'h0), .m0_data_o(p_m0_data),
    .m0_sel_i(4'hF), .m0_we_i(1'b0), .m0_cyc_i(p_cyc0), .m0_stb_i(p_cyc0),
    .m0_stall_o(p_m0_stall), .m0_ack_o(p_m0_ack),
    .m1_addr_i(32'h20), .m1_data_i(32'h0), .m1_data_o(p_m1_data),
    .m1_sel_i(4'hF), .m1_we_i(1'b0), .m1_cyc_i(p_cyc1), .m1_stb_i(p_cyc1),
    .m1_stall_o(p_m1_stall), .m1_ack_o(p_m1_ack),
    .s_addr_o(p_s_addr), .s_data_o(p_s_data), .s_sel_o(p_s_sel), .s_we_o(p_s_we),
    .s_cyc_o(p_s_cyc), .s_stb_o(p_s_stb), .s_data_i(32'h0),
    .s_stall_i(1'b0), .s_ack_i(p_ack), .err_o(p_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no/unexpected event, required the opposite", name);
  endtask

  function automatic logic [31:0] pat(input int m, input logic [31:0] a);
    return 32'hD000_0000 + (32'(m) << 24) + a;
  endfunction

  function automatic logic stall_of(input int m);
    return (m == 0) ? m0_stall_o : m1_stall_o;
  endfunction

  // Issue n strobes from master m. mode 0: wait for all acks then drop cyc;
  // mode 1: drop cyc right after the last strobe; mode 2: keep cyc raised.
  task automatic run_burst(input int m, input int n, input logic we,
                           input logic [31:0] base, input int mode);
    int   issued = 0;
    int   t = 0;
    int   a0;
    logic go;
    req_t r;
    ack_t k;
    a0 = ack_cnt[m];
    @(posedge clk_i); #1;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_addr[m] = base; m_data[m] = pat(m, base); m_sel[m] = (m == 0) ? 4'hF : 4'h3;
    while (issued < n && t < 300) begin
      @(negedge clk_i); go = !stall_of(m);
      @(posedge clk_i); #1; t++;
      if (go) begin
        r = '{addr: m_addr[m], data: m_data[m], we: we, sel: m_sel[m]};
        exp_q.push_back(r);
        if (we) ref_mem[m_addr[m]] = m_data[m];
        k.m = m; k.we = we;
        k.rdata = ref_mem.exists(m_addr[m]) ? ref_mem[m_addr[m]] : 32'h0;
        ack_q.push_back(k);
        issue_log.push_back(m);
        issued_cnt[m]++;
        issued++;
        if (issued < n) begin
          m_addr[m] = base + 32'(4 * issued);
          m_data[m] = pat(m, m_addr[m]);
        end else begin
          m_stb[m] = 1'b0;
        end
      end
    end
    check($sformatf("issued_m%0d", m), issued, n);
    if (mode == 0) begin
      t = 0;
      while (ack_cnt[m] - a0 < n && t < 300) begin
        @(posedge clk_i); #3; t++;
      end
      check($sformatf("acks_m%0d", m), ack_cnt[m] - a0, n);
      m_cyc[m] = 1'b0;
    end else if (mode == 1) begin
      m_cyc[m] = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (cycles) @(posedge clk_i);
    #1 rst_i = 1'b1;
    exp_q.delete();
    ack_q.delete();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
    end
  endtask

  // Slave model: pipelined memory, in-order acks, optional random stalls.
  initial begin : slave
    logic [31:0] pend [$];
    logic [31:0] smem [logic [31:0]];
    logic        rs, acc, ak, we;
    logic [31:0] addr, data;
    forever begin
      @(negedge clk_i);
      rs = rst_i; acc = s_cyc_o & s_stb_o & ~s_stall_i; ak = s_ack_i;
      addr = s_addr_o; data = s_data_o; we = s_we_o;
      @(posedge clk_i); #1;
      if (!rs) begin
        pend.delete();
      end else begin
        if (ak && pend.size() > 0) void'(pend.pop_front());
        if (acc) begin
          if (we) smem[addr] = data;
          pend.push_back(smem.exists(addr) ? smem[addr] : 32'h0);
        end
      end
      s_ack_i   = force_ack | (ack_en && pend.size() > 0 && $urandom_range(0, 3) != 0);
      force_ack = 1'b0;
      s_data_i  = (pend.size() > 0) ? pend[0] : 32'h0;
      s_stall_i = stall_en && ($urandom_range(0, 2) == 0);
    end
  end

  // One-cycle-latency slave for the priority instance.
  initial begin : slave_p
    logic pacc;
    forever begin
      @(negedge clk_i); pacc = p_s_cyc & p_s_stb;
      @(posedge clk_i); #1 p_ack = pacc;
    end
  end

  // Monitor / scoreboard.
  initial begin : monitor
    logic        rs, sa, a0, a1, we;
    logic [31:0] addr, data, d0, d1;
    logic [3:0]  sel;
    req_t        r;
    ack_t        k;
    int          who;
    forever begin
      @(negedge clk_i);
      rs = rst_i; sa = s_cyc_o & s_stb_o & ~s_stall_i;
      addr = s_addr_o; data = s_data_o; we = s_we_o; sel = s_sel_o;
      a0 = m0_ack_o; a1 = m1_ack_o; d0 = m0_data_o; d1 = m1_data_o;
      if (!m0_stall_o && !m1_stall_o) viol++;
      if (t1_watch && (!m1_stall_o || m1_ack_o)) viol1++;
      @(posedge clk_i); #2;
      if (rs) begin
        if (sa) begin
          if (exp_q.size() == 0) fail_event("unexpected_slave_req");
          else begin
            r = exp_q.pop_front();
            check("s_addr", addr, r.addr);
            check("s_we", 32'(we), 32'(r.we));
            check("s_sel", 32'(sel), 32'(r.sel));
            check("s_data", data, r.data);
          end
        end
        if (a0 || a1) begin
          who = a0 ? 0 : 1;
          if (a0 && a1) fail_event("double_ack");
          if (ack_q.size() == 0) fail_event("unexpected_ack");
          else begin
            k = ack_q.pop_front();
            check("ack_owner", who, k.m);
            if (!k.we) check("read_data", a0 ? d0 : d1, k.rdata);
          end
          ack_cnt[who]++;
        end
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, a0snap, a1snap, t;
    logic got;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_data[i] = '0; m_sel[i] = '0; m_we[i] = 1'b0;
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; issued_cnt[i] = 0; ack_cnt[i] = 0;
    end
    // reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_s_cyc", 32'(s_cyc_o), 0);
    check("rst_s_stb", 32'(s_stb_o), 0);
    check("rst_m0_stall", 32'(m0_stall_o), 1);
    check("rst_m1_stall", 32'(m1_stall_o), 1);
    check("rst_acks", 32'({m0_ack_o, m1_ack_o}), 0);
    check("rst_err", 32'(err_o), 0);
    @(posedge clk_i); #1 rst_i = 1'b1;

    // M0_PRIORITY=1: after master 0 wins alone, a tie still goes to master 0
    @(posedge clk_i); #1 p_cyc0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin @(negedge clk_i); got = !p_m0_stall; end
    check("prio_solo_grant", 32'(got), 1);
    @(posedge clk_i); #1 p_cyc0 = 1'b0;
    @(posedge clk_i); #1 begin p_cyc0 = 1'b1; p_cyc1 = 1'b1; end
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk_i); got = !p_m0_stall | !p_m1_stall;
    end
    check("prio_tie_m0_grant", 32'(!p_m0_stall), 1);
    check("prio_tie_m1_stall", 32'(p_m1_stall), 1);
    @(posedge clk_i); #1 begin p_cyc0 = 1'b0; p_cyc1 = 1'b0; end

    // 1: master 0 writes 16 words with random slave stalls, then reads back
    stall_en = 1'b1; ack_en = 1'b1; t1_watch = 1'b1;
    run_burst(0, 16, 1'b1, 32'h0, 0);
    run_burst(0, 16, 1'b0, 32'h0, 0);
    t1_watch = 1'b0;
    check("t1_m1_quiet", viol1, 0);

    // 2: simultaneous requests from reset, then again
    do_reset(2);
    issue_log.delete();
    fork
      run_burst(0, 4, 1'b1, 32'h100, 0);
      run_burst(1, 4, 1'b1, 32'h200, 0);
    join
    fork
      run_burst(0, 4, 1'b0, 32'h100, 0);
      run_burst(1, 4, 1'b0, 32'h200, 0);
    join
    check("t2_log_size", issue_log.size(), 16);
    if (issue_log.size() == 16) begin
      check("t2_r1_first", issue_log[0], 0);
      check("t2_r1_m0_last", issue_log[3], 0);
      check("t2_r1_m1_first", issue_log[4], 1);
      check("t2_r2_first", issue_log[8], 0);
      check("t2_r2_m1_first", issue_log[12], 1);
    end

    // 3: OUTST_W=2, acks withheld -> 3 accepted, then stalled
    stall_en = 1'b0; ack_en = 1'b0;
    base = issued_cnt[0];
    fork run_burst(0, 4, 1'b1, 32'h300, 0); join_none
    repeat (8) @(negedge clk_i);
    check("t3_accepted_at_full", issued_cnt[0] - base, 3);
    check("t3_m0_stall_full", 32'(m0_stall_o), 1);
    check("t3_s_stb_blocked", 32'(s_stb_o), 0);
    ack_en = 1'b1;
    wait fork;
    check("t3_accepted_total", issued_cnt[0] - base, 4);

    // 4: master 0 drops cyc with 2 acks pending -> DRAIN holds off master 1
    ack_en = 1'b0;
    a0snap = ack_cnt[0];
    run_burst(0, 2, 1'b0, 32'h0, 1);
    base = issued_cnt[1];
    fork run_burst(1, 2, 1'b1, 32'h400, 0); join_none
    @(posedge clk_i); @(negedge clk_i);
    check("t4_drain_cyc", 32'(s_cyc_o), 1);
    check("t4_drain_stb", 32'(s_stb_o), 0);
    check("t4_drain_m0_stall", 32'(m0_stall_o), 1);
    check("t4_drain_m1_stall", 32'(m1_stall_o), 1);
    repeat (4) @(negedge clk_i);
    check("t4_m1_held", issued_cnt[1] - base, 0);
    ack_en = 1'b1;
    wait fork;
    check("t4_m0_acks", ack_cnt[0] - a0snap, 2);
    check("t4_m1_issued", issued_cnt[1] - base, 2);

    // 5: stray ack while idle
    repeat (2) @(negedge clk_i);
    a0snap = ack_cnt[0]; a1snap = ack_cnt[1];
    check("t5_err_before", 32'(err_o), 0);
    force_ack = 1'b1;
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    check("t5_err_set", 32'(err_o), 1);
    repeat (5) @(negedge clk_i);
    check("t5_err_sticky", 32'(err_o), 1);
    check("t5_idle_cyc", 32'(s_cyc_o), 0);
    check("t5_no_master_ack", (ack_cnt[0] - a0snap) + (ack_cnt[1] - a1snap), 0);

    // 6: reset mid read burst with 3 pending
    ack_en = 1'b0;
    run_burst(0, 3, 1'b0, 32'h0, 2);
    t = 0;
    do_reset(1);
    @(negedge clk_i);
    check("t6_cyc", 32'(s_cyc_o), 0);
    check("t6_m0_stall", 32'(m0_stall_o), 1);
    check("t6_m1_stall", 32'(m1_stall_o), 1);
    check("t6_err_cleared", 32'(err_o), 0);
    ack_en = 1'b1;
    run_burst(1, 3, 1'b0, 32'h0, 0);

    check("grant_exclusive", viol, 0);
    check("queues_drained", exp_q.size() + ack_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
